// File: rtl/sha256_pkg.sv
// Shared constants, sigma functions and state type for the two-way SHA-256 message schedule.
package sha256_pkg;

    localparam int WORD_W = 32;
    localparam int ROUNDS = 64;
    localparam int UNFOLD = 2;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } sched_state_e;

    function automatic logic [WORD_W-1:0] sigma0(input logic [WORD_W-1:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
    endfunction

    function automatic logic [WORD_W-1:0] sigma1(input logic [WORD_W-1:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
    endfunction

endpackage

// File: rtl/sha256_w_expand2.sv
// Combinational two-word expansion: W[t+16] and W[t+17] from the current 16-word window.
module sha256_w_expand2
    import sha256_pkg::*;
(
    input  logic [WORD_W-1:0] w0,
    input  logic [WORD_W-1:0] w1,
    input  logic [WORD_W-1:0] w2,
    input  logic [WORD_W-1:0] w9,
    input  logic [WORD_W-1:0] w10,
    input  logic [WORD_W-1:0] w14,
    input  logic [WORD_W-1:0] w15,
    output logic [WORD_W-1:0] w_new0,
    output logic [WORD_W-1:0] w_new1
);

    // Both words read only the current window, so there is no chaining between them.
    always_comb begin
        w_new0 = sigma1(w14) + w9  + sigma0(w1) + w0;
        w_new1 = sigma1(w15) + w10 + sigma0(w2) + w1;
    end

endmodule

// File: rtl/sha256_w_schedule_x2.sv
// Two-way unfolded SHA-256 message schedule: emits W[t], W[t+1] and t per accepted step.
// Optional abort input enabled by defining SHA256_WSCHED_ABORT_EN.
module sha256_w_schedule_x2
    import sha256_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [511:0]      block_in,
    input  logic              advance,
`ifdef SHA256_WSCHED_ABORT_EN
    input  logic              abort,
`endif
    output logic              busy,
    output logic              w_valid,
    output logic [5:0]        t_out,
    output logic [WORD_W-1:0] W0_out,
    output logic [WORD_W-1:0] W1_out,
    output logic              done
);

    localparam logic [5:0] T_LAST = 6'(ROUNDS - UNFOLD);

    sched_state_e      state_q, state_d;
    logic [5:0]        t_q, t_d;
    logic [WORD_W-1:0] w_q [16];
    logic [WORD_W-1:0] w_d [16];
    logic              done_q, done_d;
    logic [WORD_W-1:0] w_new0, w_new1;
    logic              abort_hit;

`ifdef SHA256_WSCHED_ABORT_EN
    assign abort_hit = abort;
`else
    assign abort_hit = 1'b0;
`endif

    sha256_w_expand2 u_expand (
        .w0     (w_q[0]),
        .w1     (w_q[1]),
        .w2     (w_q[2]),
        .w9     (w_q[9]),
        .w10    (w_q[10]),
        .w14    (w_q[14]),
        .w15    (w_q[15]),
        .w_new0 (w_new0),
        .w_new1 (w_new1)
    );

    always_comb begin
        state_d = state_q;
        t_d     = t_q;
        done_d  = 1'b0;
        for (int unsigned i = 0; i < 16; i++) begin
            w_d[i] = w_q[i];
        end
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    for (int unsigned i = 0; i < 16; i++) begin
                        w_d[i] = block_in[WORD_W*(15-i) +: WORD_W];
                    end
                    t_d     = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (abort_hit) begin
                    t_d     = '0;
                    state_d = ST_IDLE;
                end else if (advance) begin
                    if (t_q == T_LAST) begin
                        t_d     = '0;
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        for (int unsigned i = 0; i < 14; i++) begin
                            w_d[i] = w_q[i+2];
                        end
                        w_d[14] = w_new0;
                        w_d[15] = w_new1;
                        t_d     = t_q + 6'(UNFOLD);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            t_q     <= '0;
            done_q  <= 1'b0;
            for (int unsigned i = 0; i < 16; i++) begin
                w_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            t_q     <= t_d;
            done_q  <= done_d;
            for (int unsigned i = 0; i < 16; i++) begin
                w_q[i] <= w_d[i];
            end
        end
    end

    assign busy    = (state_q == ST_RUN);
    assign w_valid = (state_q == ST_RUN);
    assign t_out   = t_q;
    assign W0_out  = w_q[0];
    assign W1_out  = w_q[1];
    assign done    = done_q;

endmodule
